// File: rtl/ram_pkg.sv
// Shared constants, clear-sequencer state type and byte-merge helper for ram_sp_be.
package ram_pkg;

    // Read-during-write behaviour selectors
    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;
    localparam int unsigned RDW_NO_CHANGE   = 2;

    // Clear sequencer states
    typedef enum logic {
        CLEAR,
        READY
    } clr_state_e;

    // Pick the new byte where its enable is set, otherwise keep the stored byte
    function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       sel);
        return sel ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/ram_sp_be_if.sv
// Port bundle for ram_sp_be: access request, read data and status.
interface ram_sp_be_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 7
);
    logic                      en;
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [ADDR_WIDTH-1:0]     address;
    logic [DATA_WIDTH-1:0]     d;
    logic [DATA_WIDTH-1:0]     q;
    logic                      q_valid;
    logic                      busy;

    modport master (
        output en, we, be, address, d,
        input  q, q_valid, busy
    );

    modport slave (
        input  en, we, be, address, d,
        output q, q_valid, busy
    );
endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once writing zero, then parks in READY.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    // Pointer carries one spare bit so the last-address compare never aliases to zero
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH + 1)'(DEPTH - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH:0]   ptr_q, ptr_d;

    // State and pointer registers; reset restarts the sweep from address 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: one zero-write per cycle while clearing, leave after the last word
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_addr = ptr_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/ram_sp_be.sv
// Single-port RAM with byte enables, registered read, selectable read-during-write
// behaviour and an optional hardware clear after reset.
module ram_sp_be
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic      clk,
    input  logic      reset,
    ram_sp_be_if.slave bus
);

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  acc;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  q_valid_q, q_valid_d;

    ram_clear_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign acc     = bus.en && !busy;
    assign rd_word = mem[bus.address];

    // Byte-merge of write data into the currently stored word
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            merged[8*i +: 8] = merge_byte(rd_word[8*i +: 8], bus.d[8*i +: 8], bus.be[i]);
        end
    end

    // Array write port: clear sequencer has priority; nothing lands while reset is held
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (acc && bus.we) begin
                mem[bus.address] <= merged;
            end
        end
    end

    // Read data selection including read-during-write behaviour
    always_comb begin
        q_d       = q_q;
        q_valid_d = 1'b0;
        if (acc) begin
            if (!bus.we) begin
                q_d       = rd_word;
                q_valid_d = 1'b1;
            end else if (RDW_MODE == RDW_WRITE_FIRST) begin
                q_d       = merged;
                q_valid_d = 1'b1;
            end else if (RDW_MODE == RDW_NO_CHANGE) begin
                q_d       = q_q;
                q_valid_d = 1'b0;
            end else begin
                q_d       = rd_word;
                q_valid_d = 1'b1;
            end
        end
    end

    // Output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.busy    = busy;

endmodule
